// File: rtl/fsm_k_read_collector.sv
// fsm_k_read_collector: frames FSM k memory reads into valid/ready words.
// A one-word pending register holds the newest capture so the word before ds can be tagged
// out_last, and a small FIFO absorbs consumer stalls.
// Optional feature macro: FSM_K_COLLECT_COUNT_EN adds out_len, the per-transaction word count
// presented alongside the last word.
module fsm_k_read_collector #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          ds,
    input  logic          mem_valid,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          overflow,
    output logic          empty_txn
`ifdef FSM_K_COLLECT_COUNT_EN
    ,
    output logic [CW-1:0] out_len
`endif
);

    if (DEPTH != (1 << AW) || DEPTH < 2 || CW == 0) begin : g_bad_param
        $error("fsm_k_read_collector: DEPTH must equal 2**AW (>=2) and CW must be nonzero");
    end

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic          pend_valid_q, pend_valid_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    // Set only in IDLE: a word captured together with ds, waiting one cycle to be pushed.
    logic          pend_last_q, pend_last_d;
    logic          empty_txn_q, empty_txn_d;
    logic          overflow_q;

    logic          capture;
    logic          push, push_last, push_ok, pop, drop;
    logic [DW-1:0] push_data;

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] mem_data [DEPTH];
    logic          mem_last [DEPTH];

`ifdef FSM_K_COLLECT_COUNT_EN
    logic [CW-1:0] cnt_q, cnt_inc;
    logic [CW-1:0] pend_len_q, pend_len_d;
    logic [CW-1:0] push_len;
    logic [CW-1:0] mem_len [DEPTH];
`endif

    assign capture    = rd & mem_valid;
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign pop        = !fifo_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

`ifdef FSM_K_COLLECT_COUNT_EN
    // Saturating count including the word captured this cycle.
    always_comb begin
        cnt_inc = cnt_q;
        if (capture && (cnt_q != {CW{1'b1}})) begin
            cnt_inc = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Next-state, pending register update and FIFO push selection.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_last_d  = pend_last_q;
        empty_txn_d  = 1'b0;
        push         = 1'b0;
        push_data    = pend_data_q;
        push_last    = 1'b0;
`ifdef FSM_K_COLLECT_COUNT_EN
        pend_len_d   = pend_len_q;
        push_len     = '0;
`endif
        case (state_q)
            StIdle: begin
                // Flush a last-tagged word left over from a capture+ds cycle.
                if (pend_valid_q) begin
                    push         = 1'b1;
                    push_last    = pend_last_q;
                    pend_valid_d = 1'b0;
                    pend_last_d  = 1'b0;
`ifdef FSM_K_COLLECT_COUNT_EN
                    push_len     = pend_last_q ? pend_len_q : '0;
`endif
                end
                if (capture) begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = din;
                    pend_last_d  = ds;
                    state_d      = ds ? StIdle : StCollect;
`ifdef FSM_K_COLLECT_COUNT_EN
                    pend_len_d   = cnt_inc;
`endif
                end else if (ds) begin
                    empty_txn_d = 1'b1;
                end
            end
            StCollect: begin
                if (capture) begin
                    push         = 1'b1;
                    pend_valid_d = 1'b1;
                    pend_data_d  = din;
                    if (ds) begin
                        pend_last_d = 1'b1;
                        state_d     = StIdle;
`ifdef FSM_K_COLLECT_COUNT_EN
                        pend_len_d  = cnt_inc;
`endif
                    end
                end else if (ds) begin
                    push         = 1'b1;
                    push_last    = 1'b1;
                    pend_valid_d = 1'b0;
                    pend_last_d  = 1'b0;
                    state_d      = StIdle;
`ifdef FSM_K_COLLECT_COUNT_EN
                    push_len     = cnt_inc;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, pending register, FIFO pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_last_q  <= 1'b0;
            empty_txn_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_last_q  <= pend_last_d;
            empty_txn_q  <= empty_txn_d;
            overflow_q   <= overflow_q | drop;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

`ifdef FSM_K_COLLECT_COUNT_EN
    // Word counter and the length carried with a pending last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            pend_len_q <= '0;
        end else begin
            cnt_q      <= ds ? '0 : cnt_inc;
            pend_len_q <= pend_len_d;
        end
    end
`endif

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_idx] <= push_data;
            mem_last[wr_idx] <= push_last;
`ifdef FSM_K_COLLECT_COUNT_EN
            mem_len[wr_idx]  <= push_len;
`endif
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? mem_data[rd_idx] : '0;
    assign out_last  = out_valid ? mem_last[rd_idx] : 1'b0;
    assign busy      = (state_q == StCollect);
    assign overflow  = overflow_q;
    assign empty_txn = empty_txn_q;
`ifdef FSM_K_COLLECT_COUNT_EN
    assign out_len   = out_valid ? mem_len[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_fsm_k_read_collector.sv
// Directed bench for fsm_k_read_collector; honours FSM_K_COLLECT_COUNT_EN when defined.
module tb_fsm_k_read_collector;

    logic       clk = 1'b0;
    logic       rst, rd, ds, mem_valid, out_ready;
    logic [7:0] din;
    logic       out_valid, out_last, busy, overflow, empty_txn;
    logic [7:0] out_data;
    logic [7:0] len_obs;
`ifdef FSM_K_COLLECT_COUNT_EN
    logic [7:0] out_len;
    assign len_obs = out_len;
`else
    assign len_obs = 8'h00;
`endif

    typedef struct packed {
        logic [7:0] len;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    fsm_k_read_collector dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .ds        (ds),
        .mem_valid (mem_valid),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .empty_txn (empty_txn)
`ifdef FSM_K_COLLECT_COUNT_EN
        ,
        .out_len   (out_len)
`endif
    );

    always #5 clk = ~clk;

    // Record every accepted beat midway between edges.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && out_valid && out_ready) begin
            b.data = out_data;
            b.last = out_last;
            b.len  = len_obs;
            q.push_back(b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rd = 1'b0; ds = 1'b0; mem_valid = 1'b0; din = 8'h00;
    endtask

    task automatic capt(input logic [7:0] d);
        rd = 1'b1; mem_valid = 1'b1; ds = 1'b0; din = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; idle_in();
        cyc(); cyc();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++; if (empty_txn !== 1'b0) begin errors++; $display("FAIL reset_empty_txn: got %b required 0", empty_txn); end
    endtask

    task automatic test_basic();
        logic [7:0] ed [3] = '{8'hA1, 8'hB2, 8'hC3};
        logic       el [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] elen [3] = '{8'd0, 8'd0, 8'd3};
        beat_t g;
        q.delete(); out_ready = 1'b1;
        capt(8'hA1); cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_first: got %b required 1", busy); end
        capt(8'hB2); cyc();
        capt(8'hC3); cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b required 1", busy); end
        idle_in(); ds = 1'b1; cyc(); ds = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy); end
        repeat (4) cyc();
        checks++; if (q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d beats required 3", q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) g = q[i]; else g = 'x;
            checks++;
            if (g.data !== ed[i] || g.last !== el[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got data=%h last=%b required data=%h last=%b", i, g.data, g.last, ed[i], el[i]);
            end
`ifdef FSM_K_COLLECT_COUNT_EN
            checks++;
            if (g.len !== elen[i]) begin errors++; $display("FAIL basic_len%0d: got %0d required %0d", i, g.len, elen[i]); end
`else
            if (elen[i] > 8'd3) $display("unexpected length table entry");
`endif
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got valid=%b required 0", out_valid); end
    endtask

    task automatic test_hold();
        beat_t g;
        q.delete(); out_ready = 1'b0;
        capt(8'h5A); cyc();
        idle_in(); ds = 1'b1; cyc(); ds = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b data=%h last=%b required valid=1 data=5a last=1", i, out_valid, out_data, out_last);
            end
            cyc();
        end
        out_ready = 1'b1; cyc(); cyc();
        if (q.size() > 0) g = q[0]; else g = 'x;
        checks++;
        if (q.size() != 1 || g.data !== 8'h5A || g.last !== 1'b1) begin
            errors++;
            $display("FAIL hold_drain: got beats=%0d data=%h last=%b required beats=1 data=5a last=1", q.size(), g.data, g.last);
        end
`ifdef FSM_K_COLLECT_COUNT_EN
        checks++; if (g.len !== 8'd1) begin errors++; $display("FAIL hold_len: got %0d required 1", g.len); end
`endif
    endtask

    task automatic test_empty_txn();
        idle_in(); ds = 1'b1; cyc(); ds = 1'b0;
        checks++;
        if (empty_txn !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL empty_pulse: got empty_txn=%b valid=%b required 1 0", empty_txn, out_valid);
        end
        cyc();
        checks++; if (empty_txn !== 1'b0) begin errors++; $display("FAIL empty_single_cycle: got %b required 0", empty_txn); end
        rd = 1'b1; mem_valid = 1'b0; ds = 1'b1; cyc(); idle_in();
        checks++;
        if (empty_txn !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL empty_no_mem_valid: got empty_txn=%b busy=%b valid=%b required 1 0 0", empty_txn, busy, out_valid);
        end
        cyc();
    endtask

    task automatic test_same_cycle();
        beat_t g0, g1;
        q.delete(); out_ready = 1'b1;
        capt(8'h11); cyc();
        capt(8'h22); ds = 1'b1; cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy: got %b required 0", busy); end
        idle_in(); repeat (4) cyc();
        if (q.size() > 0) g0 = q[0]; else g0 = 'x;
        if (q.size() > 1) g1 = q[1]; else g1 = 'x;
        checks++;
        if (q.size() != 2 || g0.data !== 8'h11 || g0.last !== 1'b0 || g1.data !== 8'h22 || g1.last !== 1'b1) begin
            errors++;
            $display("FAIL same_beats: got n=%0d %h/%b %h/%b required n=2 11/0 22/1", q.size(), g0.data, g0.last, g1.data, g1.last);
        end
`ifdef FSM_K_COLLECT_COUNT_EN
        checks++;
        if (g0.len !== 8'd0 || g1.len !== 8'd2) begin errors++; $display("FAIL same_len: got %0d %0d required 0 2", g0.len, g1.len); end
`endif
    endtask

    task automatic test_overflow();
        beat_t g;
        q.delete(); out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            capt(8'hD0 + 8'(i)); cyc();
        end
        idle_in(); ds = 1'b1; cyc(); ds = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hD0 || out_last !== 1'b0) begin
            errors++; $display("FAIL ovf_head: got valid=%b data=%h last=%b required 1 d0 0", out_valid, out_data, out_last);
        end
        out_ready = 1'b1; repeat (6) cyc();
        checks++; if (q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d beats required 4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) g = q[i]; else g = 'x;
            checks++;
            if (g.data !== (8'hD0 + 8'(i)) || g.last !== 1'b0) begin
                errors++; $display("FAIL ovf_beat%0d: got data=%h last=%b required data=%h last=0", i, g.data, g.last, 8'hD0 + 8'(i));
            end
        end
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: got overflow=%b valid=%b required 1 0", overflow, out_valid);
        end
    endtask

    task automatic test_rst_mid();
        q.delete(); out_ready = 1'b0;
        capt(8'h33); cyc(); capt(8'h44); cyc(); capt(8'h55); cyc();
        idle_in(); rst = 1'b1; cyc(); rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || empty_txn !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got valid=%b data=%h last=%b busy=%b ovf=%b empty=%b required all 0",
                     out_valid, out_data, out_last, busy, overflow, empty_txn);
        end
        ds = 1'b1; cyc(); ds = 1'b0;
        checks++; if (empty_txn !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got empty_txn=%b required 1", empty_txn); end
        out_ready = 1'b1; repeat (3) cyc();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rst_mid_discard: got %0d beats required 0", q.size()); end
    endtask

    task automatic test_full_push_pop();
        beat_t g;
        q.delete(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            capt(8'h10 + 8'(i)); cyc();
        end
        out_ready = 1'b1; capt(8'h15); cyc();
        idle_in(); ds = 1'b1; cyc(); ds = 1'b0;
        repeat (8) cyc();
        checks++; if (q.size() != 6) begin errors++; $display("FAIL fpp_count: got %0d beats required 6", q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < q.size()) g = q[i]; else g = 'x;
            checks++;
            if (g.data !== (8'h10 + 8'(i)) || g.last !== (i == 5)) begin
                errors++; $display("FAIL fpp_beat%0d: got data=%h last=%b required data=%h last=%b", i, g.data, g.last, 8'h10 + 8'(i), i == 5);
            end
        end
`ifdef FSM_K_COLLECT_COUNT_EN
        checks++; if (g.len !== 8'd6) begin errors++; $display("FAIL fpp_len: got %0d required 6", g.len); end
`endif
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow: got %b required 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_empty_txn();
        test_same_cycle();
        test_overflow();
        test_rst_mid();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
